// File: rtl/clkseq_pkg.sv
// State encodings (which double as the status output values), default parameter values
// and a small helper shared by the clock-domain reset sequencer.
package clkseq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL  = 3'd0,
    WAIT_LOCK  = 3'd1,
    SDRAM_WAIT = 3'd2,
    REL_VGA    = 3'd3,
    REL_AUD    = 3'd4,
    RUN        = 3'd5
  } clkseq_state_e;

  localparam int STATUS_W = 3;

  localparam int DEF_ARESET_CYCLES   = 4;
  localparam int DEF_LOCK_FILT       = 16;
  localparam int DEF_SDRAM_INIT_WAIT = 5000;
  localparam int DEF_STAGE_GAP       = 8;
  localparam int DEF_LOCK_TIMEOUT    = 65535;
  localparam int DEF_CNT_W           = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lock_sync_filter.sv
// Brings the asynchronous PLL lock into clk with two flops, then accepts lock only after
// LOCK_FILT consecutive synced-high cycles; clr holds the filter empty outside the lock wait.
module lock_sync_filter #(
  parameter int LOCK_FILT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pll_locked,
  input  logic clr,
  output logic locked_s,
  output logic lock_ok
);

  localparam int FW = $clog2(LOCK_FILT + 1);

  logic          meta_q;
  logic          sync_q;
  logic [FW-1:0] filt_q, filt_d;

  always_comb begin
    filt_d = filt_q;
    if (clr || !sync_q) begin
      filt_d = '0;
    end else if (filt_q != FW'(LOCK_FILT)) begin
      filt_d = filt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= '0;
    end else begin
      meta_q <= pll_locked;
      sync_q <= meta_q;
      filt_q <= filt_d;
    end
  end

  assign locked_s = sync_q;
  // The current high cycle is itself the last one of the LOCK_FILT run.
  assign lock_ok  = sync_q && !clr && (filt_q >= FW'(LOCK_FILT - 1));

endmodule

// File: rtl/clk_domain_reset_sequencer.sv
// Board PLL bring-up: PLL reset pulse, filtered lock, SDRAM power-up delay, then ordered
// SDRAM/VGA/audio reset release. CLKSEQ_TIMEOUT_EN adds a WAIT_LOCK retry timer.
module clk_domain_reset_sequencer
  import clkseq_pkg::*;
#(
  parameter int ARESET_CYCLES   = DEF_ARESET_CYCLES,
  parameter int LOCK_FILT       = DEF_LOCK_FILT,
  parameter int SDRAM_INIT_WAIT = DEF_SDRAM_INIT_WAIT,
  parameter int STAGE_GAP       = DEF_STAGE_GAP,
`ifdef CLKSEQ_TIMEOUT_EN
  parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
`endif
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                pll_locked,
  input  logic                restart,
  output logic                pll_areset,
  output logic                sdram_rst_n,
  output logic                vga_rst_n,
  output logic                aud_rst_n,
  output logic                clocks_ready,
  output logic [STATUS_W-1:0] status,
  output logic [7:0]          lock_loss_cnt
);

  clkseq_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       loss_q, loss_d;
  logic             areset_q, sdram_q, vga_q, aud_q, ready_q;
  logic             locked_s, lock_ok, lock_lost;

  lock_sync_filter #(
    .LOCK_FILT (LOCK_FILT)
  ) u_lock (
    .clk        (clk),
    .reset_n    (reset_n),
    .pll_locked (pll_locked),
    .clr        (state_q != WAIT_LOCK),
    .locked_s   (locked_s),
    .lock_ok    (lock_ok)
  );

  assign lock_lost = !locked_s && (state_q >= SDRAM_WAIT);

  // One elapsed-cycle counter serves every timed state; it restarts on each state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    loss_d  = lock_lost ? sat_inc8(loss_q) : loss_q;
    case (state_q)
      RESET_PLL:  if (cnt_q == CNT_W'(ARESET_CYCLES - 1)) state_d = WAIT_LOCK;
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = SDRAM_WAIT;
`ifdef CLKSEQ_TIMEOUT_EN
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d = RESET_PLL;
`endif
        end
      end
      SDRAM_WAIT: if (cnt_q == CNT_W'(SDRAM_INIT_WAIT - 1)) state_d = REL_VGA;
      REL_VGA:    if (cnt_q == CNT_W'(STAGE_GAP - 1)) state_d = REL_AUD;
      REL_AUD:    if (cnt_q == CNT_W'(STAGE_GAP - 1)) state_d = RUN;
      default:    state_d = state_q;
    endcase
    // Restart outranks lock loss; loss is still counted above either way.
    if (restart) begin
      state_d = RESET_PLL;
    end else if (lock_lost) begin
      state_d = WAIT_LOCK;
    end
    if (restart || (state_d != state_q)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RESET_PLL;
      cnt_q    <= '0;
      loss_q   <= 8'd0;
      areset_q <= 1'b1;
      sdram_q  <= 1'b0;
      vga_q    <= 1'b0;
      aud_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      loss_q   <= loss_d;
      areset_q <= (state_d == RESET_PLL);
      sdram_q  <= (state_d >= REL_VGA);
      vga_q    <= (state_d >= REL_AUD);
      aud_q    <= (state_d == RUN);
      ready_q  <= (state_d == RUN);
    end
  end

  assign pll_areset    = areset_q;
  assign sdram_rst_n   = sdram_q;
  assign vga_rst_n     = vga_q;
  assign aud_rst_n     = aud_q;
  assign clocks_ready  = ready_q;
  assign status        = state_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_clk_domain_reset_sequencer.sv
// Bench for clk_domain_reset_sequencer: directed timeline checks plus a per-cycle
// comparison against a phase/duration reference model under random lock drops and restarts.
module tb_clk_domain_reset_sequencer;

  localparam int ARESET    = 4;
  localparam int LOCK_FILT = 16;
  localparam int SDRAM     = 5000;
  localparam int GAP       = 8;
`ifdef CLKSEQ_TIMEOUT_EN
  localparam int TB_TIMEOUT = 100;
`endif

  logic       clk;
  logic       reset_n;
  logic       pll_locked;
  logic       restart;
  logic       pll_areset, sdram_rst_n, vga_rst_n, aud_rst_n, clocks_ready;
  logic [2:0] status;
  logic [7:0] lock_loss_cnt;

  clk_domain_reset_sequencer #(
    .ARESET_CYCLES   (ARESET),
    .LOCK_FILT       (LOCK_FILT),
    .SDRAM_INIT_WAIT (SDRAM),
    .STAGE_GAP       (GAP),
`ifdef CLKSEQ_TIMEOUT_EN
    .LOCK_TIMEOUT    (TB_TIMEOUT),
`endif
    .CNT_W           (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pll_locked    (pll_locked),
    .restart       (restart),
    .pll_areset    (pll_areset),
    .sdram_rst_n   (sdram_rst_n),
    .vga_rst_n     (vga_rst_n),
    .aud_rst_n     (aud_rst_n),
    .clocks_ready  (clocks_ready),
    .status        (status),
    .lock_loss_cnt (lock_loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: phase number, cycles spent in it, lock streak, loss count, and
  // the pll_locked values seen at recent edges (newest first) to model the sync delay.
  int m_phase, m_age, m_streak, m_loss;
  bit hist[$];

  function automatic int dur(input int ph);
    case (ph)
      0:       return ARESET;
      2:       return SDRAM;
      3, 4:    return GAP;
      default: return 0;
    endcase
  endfunction

  task automatic model_init();
    m_phase  = 0;
    m_age    = 0;
    m_streak = 0;
    m_loss   = 0;
    hist     = '{1'b0, 1'b0};
  endtask

  task automatic model_edge(input bit lk_in, input bit rs);
    bit ls;
    bit lost;
    int nxt;
    ls   = hist[1];
    lost = (m_phase >= 2) && !ls;
    nxt  = m_phase;
    if (lost && m_loss < 255) m_loss++;
    if (m_phase == 1) begin
      m_streak = ls ? m_streak + 1 : 0;
      if (m_streak >= LOCK_FILT) nxt = 2;
`ifdef CLKSEQ_TIMEOUT_EN
      else if (m_age + 1 >= TB_TIMEOUT) nxt = 0;
`endif
    end else if (m_phase != 5 && m_age + 1 >= dur(m_phase)) begin
      nxt = m_phase + 1;
    end
    if (rs) nxt = 0;
    else if (lost) nxt = 1;
    if (rs || nxt != m_phase) begin
      m_phase  = nxt;
      m_age    = 0;
      m_streak = 0;
    end else begin
      m_age++;
    end
    hist.push_front(lk_in);
    while (hist.size() > 2) void'(hist.pop_back());
  endtask

  function automatic logic [15:0] model_vec();
    logic [15:0] v;
    v = {m_phase == 0, m_phase >= 3, m_phase >= 4, m_phase == 5, m_phase == 5,
         3'(m_phase), 8'(m_loss)};
    return v;
  endfunction

  function automatic logic [15:0] dut_vec();
    return {pll_areset, sdram_rst_n, vga_rst_n, aud_rst_n, clocks_ready, status, lock_loss_cnt};
  endfunction

  bit prev_areset = 1'b0;
  int areset_rises = 0;

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge(pll_locked, restart);
    #1;
    chk("model", dut_vec(), model_vec());
    if (pll_areset && !prev_areset) areset_rises++;
    prev_areset = pll_areset;
  endtask

  task automatic wait_status(input string tag, input int target, input int budget);
    int n;
    n = 0;
    while (status != 3'(target) && n < budget) begin
      tick();
      n++;
    end
    chk(tag, status, target);
  endtask

  int fall_e, sd_e, vg_e, au_e, rd_e, acc_e, hc, r0, drop_left;

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    restart    = 1'b0;
    model_init();
    repeat (3) tick();
    chk("rst_vec", dut_vec(), 16'h8000);

    // Power-up with lock present from the start.
    reset_n = 1'b1;
    fall_e = -1; sd_e = -1; vg_e = -1; au_e = -1; rd_e = -1;
    for (int e = 1; e <= 6000 && rd_e < 0; e++) begin
      tick();
      if (fall_e < 0 && !pll_areset)  fall_e = e;
      if (sd_e < 0 && sdram_rst_n)    sd_e = e;
      if (vg_e < 0 && vga_rst_n)      vg_e = e;
      if (au_e < 0 && aud_rst_n)      au_e = e;
      if (rd_e < 0 && clocks_ready)   rd_e = e;
    end
    chk("areset_fall", fall_e, ARESET);
    chk("sdram_rise", sd_e, ARESET + LOCK_FILT + SDRAM);
    chk("vga_rise", vg_e, ARESET + LOCK_FILT + SDRAM + GAP);
    chk("aud_rise", au_e, ARESET + LOCK_FILT + SDRAM + 2 * GAP);
    chk("ready_rise", rd_e, ARESET + LOCK_FILT + SDRAM + 2 * GAP);

    // Lock lost for 3 cycles while running.
    r0 = areset_rises;
    pll_locked = 1'b0;
    repeat (3) tick();
    pll_locked = 1'b1;
    chk("loss_rst", {sdram_rst_n, vga_rst_n, aud_rst_n, clocks_ready}, 0);
    chk("loss_cnt", lock_loss_cnt, 1);
    wait_status("loss_rerun", 5, 6000);
    chk("loss_no_pulse", areset_rises - r0, 0);
    chk("loss_cnt_hold", lock_loss_cnt, 1);

    // Restart, then a one-cycle lock glitch after 10 filtered highs.
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_status", status, 0);
    acc_e = -1;
    for (int i = 1; i <= 60 && acc_e < 0; i++) begin
      pll_locked = (i == ARESET + 9) ? 1'b0 : 1'b1;
      tick();
      if (status == 3'd2) acc_e = i;
    end
    pll_locked = 1'b1;
    chk("glitch_acc", acc_e, ARESET + 10 + 1 + LOCK_FILT);

    // Restart during the VGA release stage.
    wait_status("to_rel_vga", 3, 6000);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    chk("rs_sdram", sdram_rst_n, 0);
    chk("rs_state", status, 0);
    hc = 0;
    for (int i = 0; i < 20 && pll_areset; i++) begin
      hc++;
      tick();
    end
    chk("areset_len", hc, ARESET);
    wait_status("rs_rerun", 5, 6000);

    // Saturate the lock-loss counter.
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      repeat (3) tick();
      pll_locked = 1'b1;
      wait_status("sat_relock", 2, 200);
    end
    chk("loss_sat", lock_loss_cnt, 255);

    // Asynchronous reset in the middle of the audio release stage.
    wait_status("to_rel_aud", 4, 6000);
    repeat (3) tick();
    reset_n = 1'b0;
    #1;
    chk("async_rst", dut_vec(), 16'h8000);
    model_init();
    repeat (2) tick();

    // No lock at all: only the timeout build retries the PLL reset.
    pll_locked = 1'b0;
    reset_n = 1'b1;
    r0 = areset_rises;
    repeat (520) tick();
`ifdef CLKSEQ_TIMEOUT_EN
    chk("timeout_pulses", areset_rises - r0, 5);
    chk("timeout_areset", pll_areset, 1);
`else
    chk("timeout_pulses", areset_rises - r0, 0);
    chk("timeout_areset", pll_areset, 0);
`endif

    // Random lock drops and restarts.
    drop_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (drop_left > 0) begin
        pll_locked = 1'b0;
        drop_left--;
      end else begin
        pll_locked = 1'b1;
        if ($urandom_range(0, 149) == 0) drop_left = $urandom_range(1, 4);
      end
      restart = ($urandom_range(0, 399) == 0);
      tick();
    end
    restart = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
